// File: rtl/btb_pkg.sv
// Shared types for the set-associative BTB: entry layout, 2-bit counter encodings and update.
// Build option: define BTB_COUNTER_EN to add per-entry 2-bit direction counters.
package btb_pkg;

    // Tags are stored at the widest legal size; unused upper bits are always written as zero.
    localparam int TAG_MAX = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        imm;
`ifdef BTB_COUNTER_EN
        ctr_e               ctr;
`endif
    } entry_t;

    function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_e'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU for one BTB set: picks the victim way and computes the bits after an access.
// Bit 0 is the root; a 0 steers the victim toward the lower-numbered half.
module btb_plru #(
    parameter int  WAYS = 2,
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PW-1:0] plru_i,
    input  logic [WW-1:0] access_i,
    output logic [WW-1:0] victim_o,
    output logic [PW-1:0] plru_o
);

    generate
        if (WAYS == 4) begin : g_four
            always_comb begin
                victim_o = {plru_i[0], plru_i[0] ? plru_i[2] : plru_i[1]};
            end

            // Point every node on the accessed path away from the accessed way.
            always_comb begin
                plru_o = plru_i;
                if (!access_i[1]) begin
                    plru_o[0] = 1'b1;
                    plru_o[1] = ~access_i[0];
                end else begin
                    plru_o[0] = 1'b0;
                    plru_o[2] = ~access_i[0];
                end
            end
        end else if (WAYS == 2) begin : g_two
            always_comb begin
                victim_o = plru_i;
                plru_o   = ~access_i;
            end
        end else begin : g_one
            logic unused_access;
            assign unused_access = ^access_i;
            always_comb begin
                victim_o = '0;
                plru_o   = plru_i;
            end
        end
    endgenerate

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with tree-PLRU replacement and combinational lookup.
// Build option: BTB_COUNTER_EN adds 2-bit counters; without it a not-taken hit evicts the entry.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int TAG_SIZE   = 20,
    parameter int INDEX_SIZE = 6,
    parameter int WAYS       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic        BTBHit,
    output logic        predTakenF,
    output logic [31:0] branchimmF,
    input  logic        updEn,
    input  logic [31:0] updPc,
    input  logic [31:0] updImm,
    input  logic        updTaken,
    input  logic        flush
);

    localparam int SETS = 1 << INDEX_SIZE;
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    entry_t          mem_q  [SETS][WAYS];
    logic [PW-1:0]   plru_q [SETS];

    logic [INDEX_SIZE-1:0] fIdx, uIdx;
    logic [TAG_MAX-1:0]    fTag, uTag;
    entry_t                hitEntry, entry_d;
    logic                  uHit, uFree;
    logic [WW-1:0]         uHitWay, uFreeWay, uVictim, uWay;
    logic [PW-1:0]         plru_d;
    logic                  unused_pc;

    assign fIdx      = pcF[INDEX_SIZE+1:2];
    assign uIdx      = updPc[INDEX_SIZE+1:2];
    assign fTag      = TAG_MAX'(pcF[TAG_SIZE+INDEX_SIZE+1:INDEX_SIZE+2]);
    assign uTag      = TAG_MAX'(updPc[TAG_SIZE+INDEX_SIZE+1:INDEX_SIZE+2]);
    assign unused_pc = ^{pcF, updPc};

    always_comb begin
        BTBHit   = 1'b0;
        hitEntry = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem_q[fIdx][w].valid && (mem_q[fIdx][w].tag == fTag)) begin
                BTBHit   = 1'b1;
                hitEntry = mem_q[fIdx][w];
            end
        end
    end

    assign branchimmF = hitEntry.imm;
`ifdef BTB_COUNTER_EN
    assign predTakenF = BTBHit & hitEntry.ctr[1];
`else
    assign predTakenF = BTBHit;
`endif

    // Scanning downward leaves the lowest-numbered invalid way as the free candidate.
    always_comb begin
        uHit     = 1'b0;
        uHitWay  = '0;
        uFree    = 1'b0;
        uFreeWay = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!mem_q[uIdx][w].valid) begin
                uFree    = 1'b1;
                uFreeWay = WW'(w);
            end
            if (mem_q[uIdx][w].valid && (mem_q[uIdx][w].tag == uTag)) begin
                uHit    = 1'b1;
                uHitWay = WW'(w);
            end
        end
    end

    assign uWay = uHit ? uHitWay : (uFree ? uFreeWay : uVictim);

    btb_plru #(.WAYS(WAYS)) uPlru (
        .plru_i   (plru_q[uIdx]),
        .access_i (uWay),
        .victim_o (uVictim),
        .plru_o   (plru_d)
    );

    always_comb begin
        entry_d     = mem_q[uIdx][uWay];
        entry_d.imm = updImm;
        if (uHit) begin
`ifdef BTB_COUNTER_EN
            entry_d.ctr = ctr_update(entry_d.ctr, updTaken);
`else
            entry_d.valid = updTaken;
`endif
        end else begin
            entry_d.valid = 1'b1;
            entry_d.tag   = uTag;
`ifdef BTB_COUNTER_EN
            entry_d.ctr   = WT;
`endif
        end
    end

    // A not-taken update that misses touches nothing, PLRU included.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    mem_q[s][w].valid <= 1'b0;
`ifdef BTB_COUNTER_EN
                    mem_q[s][w].ctr   <= WNT;
`endif
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem_q[s][w].valid <= 1'b0;
                end
            end
        end else if (updEn && (uHit || updTaken)) begin
            mem_q[uIdx][uWay] <= entry_d;
            plru_q[uIdx]      <= plru_d;
        end
    end

endmodule
